smem_arbiter: RTL and testbench

- Arbitrates load/store requests from N_CORES gpu cores onto one single-port shared data memory.
- Round-robin grant; one access in flight at a time.
- Returns load data and store acknowledgement to the granted core using the core's mem_req_ld/mem_req_st/mem_dat/val_data handshake.
- Sits between the core array and the shared memory macro.

---
 rtl/smem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_smem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smem_arbiter.sv
// ---------------------------------------------------------------------------
// smem_arbiter
//   Round-robin arbiter that multiplexes per-core load/store requests onto a
//   single-port shared data memory. Only one access is in flight at a time.
//   Load data is returned on a bus shared by all cores. A one-hot, one-cycle
//   core_val_data pulse tells the granted core that its load data is valid
//   or that its store has completed.
//
//   Ports
//     clk, reset      rising-edge clock, synchronous active-high reset
//     core_req_ld     per-core load request (level, held until acked)
//     core_req_st     per-core store request (level, held until acked)
//     core_addr       packed per-core addresses, core i at [i*AW +: AW]
//     core_dat_st     packed per-core store data, core i at [i*DW +: DW]
//     core_val_data   one-hot ack: load data valid / store done
//     core_mem_dat    load data broadcast to all cores
//     mem_addr        shared-memory address
//     mem_re, mem_we  shared-memory read / write strobes
//     mem_wdata       shared-memory write data
//     mem_rdata       shared-memory read data, LD_LAT cycles after mem_re
//     busy            high whenever the arbiter is not idle
//     grant_id        index of the current / most recent winner
//
//   Optional feature macro: SMEM_ARB_CORE0_PRIO_EN
//     When it is defined, core 0 (the control core) wins every arbitration in
//     which it is pending. The round-robin pointer only follows grants to
//     cores 1..N_CORES-1, so fairness among those cores is kept.
// ---------------------------------------------------------------------------
module smem_arbiter #(
   parameter int N_CORES = 4,
   parameter int AW      = 12,
   parameter int DW      = 8,
   parameter int LD_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CORES-1:0]    core_req_ld,
   input  logic [N_CORES-1:0]    core_req_st,
   input  logic [N_CORES*AW-1:0] core_addr,
   input  logic [N_CORES*DW-1:0] core_dat_st,
   output logic [N_CORES-1:0]    core_val_data,
   output logic [DW-1:0]         core_mem_dat,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DW-1:0]         mem_wdata,
   input  logic [DW-1:0]         mem_rdata,
   output logic                  busy,
   output logic [3:0]            grant_id
);

   localparam int            CW       = (LD_LAT > 1) ? $clog2(LD_LAT) : 1;
   localparam logic [CW-1:0] LAT_INIT = CW'(LD_LAT - 1);
   localparam logic [3:0]    PTR_RST  = 4'(N_CORES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state;
   logic [3:0]           rr_ptr;
   logic [CW-1:0]        lat_cnt;
   logic                 win_st;

   logic [N_CORES-1:0]   pending;
   logic                 sel_vld;
   logic [3:0]           sel_idx;
   logic [AW-1:0]        sel_addr;
   logic [DW-1:0]        sel_dat;
   logic                 sel_st;
   logic [N_CORES-1:0]   win_onehot;

   assign pending = core_req_ld | core_req_st;

   // Arbitration: first pending core found searching upward from rr_ptr+1,
   // wrapping modulo N_CORES. The inner loop uses constant indices so the
   // winner's address/data are picked without variable part-selects.
   // A store wins over a load from the same core; the load stays pending.
   always_comb begin
      int j;
      j        = 0;
      sel_vld  = 1'b0;
      sel_idx  = '0;
      sel_addr = '0;
      sel_dat  = '0;
      sel_st   = 1'b0;
`ifdef SMEM_ARB_CORE0_PRIO_EN
      if (pending[0]) begin
         sel_vld  = 1'b1;
         sel_idx  = '0;
         sel_addr = core_addr[0 +: AW];
         sel_dat  = core_dat_st[0 +: DW];
         sel_st   = core_req_st[0];
      end
`endif
      for (int k = 1; k <= N_CORES; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N_CORES) j = j - N_CORES;
         for (int i = 0; i < N_CORES; i++) begin
            if (!sel_vld && (i == j) && pending[i]) begin
               sel_vld  = 1'b1;
               sel_idx  = 4'(i);
               sel_addr = core_addr[i*AW +: AW];
               sel_dat  = core_dat_st[i*DW +: DW];
               sel_st   = core_req_st[i];
            end
         end
      end
   end

   always_comb begin
      win_onehot = '0;
      for (int i = 0; i < N_CORES; i++) begin
         win_onehot[i] = (grant_id == 4'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rr_ptr        <= PTR_RST;
         lat_cnt       <= '0;
         win_st        <= 1'b0;
         core_val_data <= '0;
         core_mem_dat  <= '0;
         mem_addr      <= '0;
         mem_re        <= 1'b0;
         mem_we        <= 1'b0;
         mem_wdata     <= '0;
         busy          <= 1'b0;
         grant_id      <= '0;
      end else begin
         case (state)
            // Grant: latch the winner and launch its strobe for the ISSUE cycle
            IDLE: begin
               if (sel_vld) begin
                  grant_id  <= sel_idx;
                  win_st    <= sel_st;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_dat;
                  mem_we    <= sel_st;
                  mem_re    <= ~sel_st;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            // Strobe cycle: drop strobes, advance the pointer, pick the response path
            ISSUE: begin
               mem_we  <= 1'b0;
               mem_re  <= 1'b0;
               lat_cnt <= LAT_INIT;
`ifdef SMEM_ARB_CORE0_PRIO_EN
               if (grant_id != 4'd0) rr_ptr <= grant_id;
`else
               rr_ptr  <= grant_id;
`endif
               if (win_st) begin
                  core_val_data <= win_onehot;
                  state         <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            // Read latency: capture mem_rdata on the cycle it becomes valid
            WAIT: begin
               if (lat_cnt == '0) begin
                  core_mem_dat  <= mem_rdata;
                  core_val_data <= win_onehot;
                  state         <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - CW'(1);
               end
            end
            // Ack cycle: the pulse ends, arbiter returns to idle
            RESP: begin
               core_val_data <= '0;
               busy          <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_smem_arbiter.sv
`timescale 1ns/1ps
module tb_smem_arbiter;

   localparam int N      = 4;
   localparam int AW     = 12;
   localparam int DW     = 8;
   localparam int LD_LAT = 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    core_req_ld, core_req_st;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_dat_st;
   logic [N-1:0]    core_val_data;
   logic [DW-1:0]   core_mem_dat;
   logic [AW-1:0]   mem_addr;
   logic            mem_re, mem_we;
   logic [DW-1:0]   mem_wdata, mem_rdata;
   logic            busy;
   logic [3:0]      grant_id;

   smem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .LD_LAT(LD_LAT)) dut (
      .clk(clk), .reset(reset),
      .core_req_ld(core_req_ld), .core_req_st(core_req_st),
      .core_addr(core_addr), .core_dat_st(core_dat_st),
      .core_val_data(core_val_data), .core_mem_dat(core_mem_dat),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Transaction-level reference: a grant decided in idle cycle g schedules
   // the strobe at g+1, read capture at g+1+LD_LAT and ack at g+2 (store) or
   // g+2+LD_LAT (load); the arbiter is idle again on the cycle after the ack.
   int            cyc = 0, g_cyc = -100, a_cyc = -100, cap_cyc = -100;
   int            rr = N - 1, m_win = 0;
   bit            m_st = 1'b0, chk_en = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wd = '0, e_dat = '0;
   logic [3:0]    e_gid = '0;
   logic [N-1:0]  drop_vec = '0;
   bit            drop_st = 1'b0;

   always @(negedge clk) begin
      logic [N-1:0] e_val;
      logic [N-1:0] pend;
      bit           strobe;
      int           w;
      cyc++;
      strobe = (cyc == g_cyc + 1);
      e_val  = (cyc == a_cyc) ? N'(1 << m_win) : '0;
      if (chk_en) begin
         chk("busy",     32'(busy),          32'(cyc > g_cyc && cyc <= a_cyc));
         chk("mem_we",   32'(mem_we),        32'(strobe && m_st));
         chk("mem_re",   32'(mem_re),        32'(strobe && !m_st));
         if (strobe)         chk("mem_addr",  32'(mem_addr),  32'(m_addr));
         if (strobe && m_st) chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
         chk("val_data", 32'(core_val_data), 32'(e_val));
         chk("grant_id", 32'(grant_id),      32'(e_gid));
         chk("mem_dat",  32'(core_mem_dat),  32'(e_dat));
      end
      drop_vec = e_val;
      drop_st  = m_st;
      if (reset) begin
         g_cyc = -100; a_cyc = -100; cap_cyc = -100;
         rr = N - 1; m_win = 0; m_st = 1'b0;
         e_dat = '0; e_gid = '0;
         chk_en = 1'b1;
      end else begin
         if (cyc == cap_cyc) e_dat = mem_rdata;
         pend = core_req_ld | core_req_st;
         if (cyc > a_cyc && pend != '0) begin
            w = -1;
`ifdef SMEM_ARB_CORE0_PRIO_EN
            if (pend[0]) w = 0;
`endif
            for (int k = 1; k <= N; k++)
               if (w < 0 && pend[(rr + k) % N]) w = (rr + k) % N;
            m_win   = w;
            m_st    = core_req_st[w];
            m_addr  = core_addr[w*AW +: AW];
            m_wd    = core_dat_st[w*DW +: DW];
            g_cyc   = cyc;
            a_cyc   = m_st ? cyc + 2 : cyc + 2 + LD_LAT;
            cap_cyc = m_st ? -100 : cyc + 1 + LD_LAT;
            e_gid   = 4'(w);
`ifdef SMEM_ARB_CORE0_PRIO_EN
            if (w != 0) rr = w;
`else
            rr = w;
`endif
         end
      end
   end

   logic [N-1:0] hold_ld = '0, hold_st = '0;
   bit           fix_rdata = 1'b0;

   // One clock: requesters drop the serviced request on the ack edge.
   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         if (drop_vec[i]) begin
            if (drop_st) core_req_st[i] = 1'b0;
            else         core_req_ld[i] = 1'b0;
         end
      core_req_ld = core_req_ld | hold_ld;
      core_req_st = core_req_st | hold_st;
      if (!fix_rdata) mem_rdata = DW'($urandom);
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      core_req_ld = '0; core_req_st = '0; hold_ld = '0; hold_st = '0;
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic set_core(int i, logic [AW-1:0] a, logic [DW-1:0] d);
      core_addr[i*AW +: AW]   = a;
      core_dat_st[i*DW +: DW] = d;
   endtask

   task automatic wait_ack(output logic [N-1:0] v, output logic [3:0] g);
      int t;
      t = 0;
      do begin step(); t++; end while (core_val_data == '0 && t < 40);
      v = core_val_data;
      g = grant_id;
   endtask

   int exp3[5] = '{0, 1, 2, 3, 0};
`ifdef SMEM_ARB_CORE0_PRIO_EN
   int exp6[4] = '{0, 0, 0, 0};
`else
   int exp6[4] = '{0, 1, 0, 1};
`endif

   initial begin
      logic [N-1:0] v;
      logic [3:0]   g;
      int           t;
      reset = 1'b1;
      core_req_ld = '0; core_req_st = '0;
      core_addr = '0; core_dat_st = '0; mem_rdata = '0;

      // Reset state
      do_reset(3);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_val",  32'(core_val_data), 32'(0));
      chk("rst_we",   32'(mem_we), 32'(0));
      chk("rst_re",   32'(mem_re), 32'(0));
      chk("rst_gid",  32'(grant_id), 32'(0));
      chk("rst_dat",  32'(core_mem_dat), 32'(0));

      // Core 2 store 0x5A -> 0x012
      set_core(2, 12'h012, 8'h5A); core_req_st[2] = 1'b1;
      step();
      chk("st_we",    32'(mem_we), 32'(1));
      chk("st_re",    32'(mem_re), 32'(0));
      chk("st_addr",  32'(mem_addr), 32'h012);
      chk("st_wdata", 32'(mem_wdata), 32'h5A);
      chk("st_busy1", 32'(busy), 32'(1));
      step();
      chk("st_ack",   32'(core_val_data), 32'b0100);
      chk("st_busy2", 32'(busy), 32'(1));
      step();
      chk("st_idle",  32'(busy), 32'(0));

      // Core 1 load from 0x018, memory returns 0x07
      fix_rdata = 1'b1; mem_rdata = 8'h07;
      set_core(1, 12'h018, 8'h00); core_req_ld[1] = 1'b1;
      step();
      chk("ld_re",   32'(mem_re), 32'(1));
      chk("ld_we",   32'(mem_we), 32'(0));
      chk("ld_addr", 32'(mem_addr), 32'h018);
      step();
      chk("ld_wait", 32'(core_val_data), 32'(0));
      step();
      chk("ld_ack",  32'(core_val_data), 32'b0010);
      chk("ld_dat",  32'(core_mem_dat), 32'h07);
      step();
      fix_rdata = 1'b0;

      // All four cores hold loads from reset: order 0,1,2,3,0
      do_reset(2);
      for (int i = 0; i < N; i++) set_core(i, AW'(12'h100 + i), DW'(i));
      hold_ld = '1; core_req_ld = '1;
      for (int k = 0; k < 5; k++) begin
         wait_ack(v, g);
         chk("rr_ack", 32'(v), 32'(1 << exp3[k]));
         chk("rr_gid", 32'(g), 32'(exp3[k]));
      end
      hold_ld = '0; core_req_ld = '0;
      repeat (8) step();

      // Core 3 with both ld and st: store first, load in a later round
      set_core(3, 12'h0A5, 8'h3C); core_req_ld[3] = 1'b1; core_req_st[3] = 1'b1;
      step();
      chk("both_we",  32'(mem_we), 32'(1));
      chk("both_gid", 32'(grant_id), 32'(3));
      step();
      chk("both_ack_st", 32'(core_val_data), 32'b1000);
      step();
      step();
      chk("both_re",  32'(mem_re), 32'(1));
      chk("both_we2", 32'(mem_we), 32'(0));
      step();
      step();
      chk("both_ack_ld", 32'(core_val_data), 32'b1000);
      step();
      repeat (4) step();

      // Reset during WAIT of a core 2 load
      set_core(2, 12'h111, 8'h00); core_req_ld[2] = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rw_busy", 32'(busy), 32'(0));
      chk("rw_val",  32'(core_val_data), 32'(0));
      chk("rw_re",   32'(mem_re), 32'(0));
      core_req_ld[0] = 1'b1; core_req_ld[1] = 1'b1;
      step();
      chk("rw_re2",  32'(mem_re), 32'(1));
      chk("rw_gid",  32'(grant_id), 32'(0));
      step();
      chk("rw_val2", 32'(core_val_data), 32'(0));
      step();
      chk("rw_ack",  32'(core_val_data), 32'b0001);
      core_req_ld = '0;
      repeat (8) step();

      // Cores 0 and 1 requesting stores continuously
      do_reset(2);
      set_core(0, 12'h200, 8'hA0); set_core(1, 12'h201, 8'hA1);
      hold_st = 4'b0011; core_req_st = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         wait_ack(v, g);
         chk("c01_ack", 32'(v), 32'(1 << exp6[k]));
      end
      hold_st = '0; core_req_st = '0;
      repeat (6) step();

      // Randomized traffic with withdrawals and occasional resets
      for (t = 0; t < 3000; t++) begin
         step();
         reset = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < N; i++) begin
            if (!core_req_ld[i] && !core_req_st[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  int ty;
                  ty = $urandom_range(0, 2);
                  core_req_ld[i] = (ty != 1);
                  core_req_st[i] = (ty != 0);
                  set_core(i, AW'($urandom), DW'($urandom));
               end
            end else if ($urandom_range(0, 31) == 0) begin
               core_req_ld[i] = 1'b0;
               core_req_st[i] = 1'b0;
            end
         end
      end
      reset = 1'b0;
      core_req_ld = '0; core_req_st = '0;
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
